// File: rtl/vec_hazard_scoreboard.sv
// vec_hazard_scoreboard: scoreboard RAW hazard controller for the F/D/E/M/W
// vector pipeline. Tracks in-flight writes (RegWrite destination and SPWrite
// base writeback) with one down-counter per register, stalls F/D and bubbles E
// on a RAW hazard, and offers a drain handshake.
// Optional feature macro: HAZARD_PERF_EN (adds StallCount / IssueCount).
module vec_hazard_scoreboard #(
  parameter int unsigned NREG   = 16,
  parameter int unsigned WB_LAT = 3
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            ValidD,
  input  logic [31:0]     InstrD,
  input  logic            RegSrcD,
  input  logic            UseA1D,
  input  logic            UseA2D,
  input  logic            RegWriteD,
  input  logic            SPWriteD,
  input  logic            DrainReq,
  output logic            StallF,
  output logic            StallD,
  output logic            FlushE,
  output logic            DrainAck,
  output logic [NREG-1:0] BusyRegs
`ifdef HAZARD_PERF_EN
  ,
  output logic [31:0]     StallCount,
  output logic [31:0]     IssueCount
`endif
);

  localparam int unsigned AW = $clog2(NREG);
  localparam int unsigned CW = $clog2(WB_LAT + 1);
  localparam logic [CW-1:0] LOAD_VAL = CW'(WB_LAT);

  typedef enum logic [1:0] {
    ST_RUN      = 2'd0,
    ST_DRAINING = 2'd1,
    ST_DRAINED  = 2'd2
  } state_t;

  state_t          r_state;
  state_t          w_state_nxt;
  logic [CW-1:0]   r_cnt [NREG];
  logic [AW-1:0]   w_rd;
  logic [AW-1:0]   w_rb;
  logic [AW-1:0]   w_a2;
  logic            w_hazard;
  logic            w_drain_block;
  logic            w_block;
  logic            w_issue;
  logic            w_all_idle;
  logic [NREG-1:0] w_load;
  logic            w_unused;

  // Register fields of the D-stage instruction; A1 and SPWrite base share [20:17].
  assign w_rd = AW'(InstrD[24:21]);
  assign w_rb = AW'(InstrD[20:17]);
  assign w_a2 = RegSrcD ? AW'(InstrD[24:21]) : AW'(InstrD[16:13]);

  // Opcode/immediate bits are not needed for hazard detection.
  assign w_unused = ^{InstrD[31:25], InstrD[12:0]};

  // RAW hazard against pre-load counters, so a writer never stalls on itself.
  assign w_hazard = ValidD &
                    ((UseA1D & (r_cnt[w_rb] != '0)) |
                     (UseA2D & (r_cnt[w_a2] != '0)));

  assign w_block = w_hazard | w_drain_block;
  assign w_issue = ValidD & ~w_block;
  assign StallF  = w_block;
  assign StallD  = w_block;
  assign FlushE  = w_block;

  // Busy bitmap and counter-load decode; a dual write to one register loads once.
  always_comb begin
    BusyRegs = '0;
    w_load   = '0;
    for (int r = 0; r < int'(NREG); r++) begin
      BusyRegs[AW'(r)] = (r_cnt[AW'(r)] != '0);
    end
    if (w_issue && RegWriteD) w_load[w_rd] = 1'b1;
    if (w_issue && SPWriteD)  w_load[w_rb] = 1'b1;
  end

  assign w_all_idle = ~|BusyRegs;

  // Per-register busy counters: load on issue (restarts WAW), else count down.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int r = 0; r < int'(NREG); r++) begin
        r_cnt[AW'(r)] <= '0;
      end
    end else begin
      for (int r = 0; r < int'(NREG); r++) begin
        if (w_load[AW'(r)]) begin
          r_cnt[AW'(r)] <= LOAD_VAL;
        end else if (r_cnt[AW'(r)] != '0) begin
          r_cnt[AW'(r)] <= r_cnt[AW'(r)] - CW'(1);
        end
      end
    end
  end

  // Drain FSM state register.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state <= ST_RUN;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Drain FSM next state and outputs; releasing DrainReq in DRAINED frees issue at once.
  always_comb begin
    w_state_nxt   = r_state;
    w_drain_block = 1'b0;
    DrainAck      = 1'b0;
    case (r_state)
      ST_RUN: begin
        if (DrainReq) w_state_nxt = ST_DRAINING;
      end
      ST_DRAINING: begin
        w_drain_block = 1'b1;
        if (!DrainReq)       w_state_nxt = ST_RUN;
        else if (w_all_idle) w_state_nxt = ST_DRAINED;
      end
      ST_DRAINED: begin
        w_drain_block = DrainReq;
        DrainAck      = DrainReq;
        if (!DrainReq) w_state_nxt = ST_RUN;
      end
      default: begin
        w_state_nxt = ST_RUN;
      end
    endcase
  end

`ifdef HAZARD_PERF_EN
  logic [31:0] r_stall_cnt;
  logic [31:0] r_issue_cnt;

  // Saturating counters of hazard stall cycles and issued instructions.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_stall_cnt <= '0;
      r_issue_cnt <= '0;
    end else begin
      if (w_hazard && (r_stall_cnt != '1)) r_stall_cnt <= r_stall_cnt + 32'd1;
      if (w_issue && (r_issue_cnt != '1))  r_issue_cnt <= r_issue_cnt + 32'd1;
    end
  end

  assign StallCount = r_stall_cnt;
  assign IssueCount = r_issue_cnt;
`endif

endmodule

// File: tb/tb_vec_hazard_scoreboard.sv
// Directed, table-driven bench for vec_hazard_scoreboard.
module tb_vec_hazard_scoreboard;

  logic        clk = 1'b0;
  logic        reset;
  logic        ValidD, RegSrcD, UseA1D, UseA2D, RegWriteD, SPWriteD, DrainReq;
  logic [31:0] InstrD;
  logic        StallF, StallD, FlushE, DrainAck;
  logic [15:0] BusyRegs;
`ifdef HAZARD_PERF_EN
  logic [31:0] StallCount, IssueCount;
`endif

  int checks   = 0;
  int failures = 0;

  vec_hazard_scoreboard #(.NREG(16), .WB_LAT(3)) dut (
    .clk       (clk),
    .reset     (reset),
    .ValidD    (ValidD),
    .InstrD    (InstrD),
    .RegSrcD   (RegSrcD),
    .UseA1D    (UseA1D),
    .UseA2D    (UseA2D),
    .RegWriteD (RegWriteD),
    .SPWriteD  (SPWriteD),
    .DrainReq  (DrainReq),
    .StallF    (StallF),
    .StallD    (StallD),
    .FlushE    (FlushE),
    .DrainAck  (DrainAck),
    .BusyRegs  (BusyRegs)
`ifdef HAZARD_PERF_EN
    ,
    .StallCount(StallCount),
    .IssueCount(IssueCount)
`endif
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        v;
    logic [3:0]  rd, rb, rs;
    logic        src, a1, a2, rw, sp, dr;
    logic        e_stall, e_ack;
    logic [15:0] e_busy;
  } vec_t;

  vec_t vecs [64];
  int   nvec = 0;

  task automatic add(input logic v, input logic [3:0] rd, input logic [3:0] rb,
                     input logic [3:0] rs, input logic src, input logic a1,
                     input logic a2, input logic rw, input logic sp, input logic dr,
                     input logic es, input logic ea, input logic [15:0] eb);
    vecs[nvec].v  = v;   vecs[nvec].rd = rd;  vecs[nvec].rb = rb;
    vecs[nvec].rs = rs;  vecs[nvec].src = src; vecs[nvec].a1 = a1;
    vecs[nvec].a2 = a2;  vecs[nvec].rw = rw;  vecs[nvec].sp = sp;
    vecs[nvec].dr = dr;  vecs[nvec].e_stall = es; vecs[nvec].e_ack = ea;
    vecs[nvec].e_busy = eb;
    nvec++;
  endtask

  task automatic drive(input vec_t x);
    ValidD    = x.v;
    InstrD    = {7'd0, x.rd, x.rb, x.rs, 13'd0};
    RegSrcD   = x.src;
    UseA1D    = x.a1;
    UseA2D    = x.a2;
    RegWriteD = x.rw;
    SPWriteD  = x.sp;
    DrainReq  = x.dr;
  endtask

  task automatic chk(input string name, input int idx, input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s idx=%0d got=%h want=%h", name, idx, act, exp);
    end
  endtask

  task automatic chk_outs(input int idx, input logic es, input logic ea,
                          input logic [15:0] eb);
    chk("stall", idx, {29'd0, StallF, StallD, FlushE}, {29'd0, {3{es}}});
    chk("ack",   idx, {31'd0, DrainAck}, {31'd0, ea});
    chk("busy",  idx, {16'd0, BusyRegs}, {16'd0, eb});
  endtask

  vec_t tmp;

  initial begin
    // Columns: v rd rb rs src a1 a2 rw sp dr | stall ack busy
    // Back-to-back RAW on R5 via A1.
    add(1, 5, 0, 0, 0, 0, 0, 1, 0, 0, 0, 0, 16'h0000);
    add(1, 0, 5, 0, 0, 1, 0, 0, 0, 0, 1, 0, 16'h0020);
    add(1, 0, 5, 0, 0, 1, 0, 0, 0, 0, 1, 0, 16'h0020);
    add(1, 0, 5, 0, 0, 1, 0, 0, 0, 0, 1, 0, 16'h0020);
    add(1, 0, 5, 0, 0, 1, 0, 0, 0, 0, 0, 0, 16'h0000);
    // Independent: writer R2, reader R7/R8; bubble with hazard-like fields.
    add(1, 2, 0, 0, 0, 0, 0, 1, 0, 0, 0, 0, 16'h0000);
    add(1, 0, 7, 8, 0, 1, 1, 0, 0, 0, 0, 0, 16'h0004);
    add(0, 9, 2, 2, 0, 1, 1, 1, 0, 0, 0, 0, 16'h0004);
    add(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 16'h0004);
    add(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 16'h0000);
    // WAW restart on R4, then A2 reader stalls the remaining count.
    add(1, 4, 0, 0, 0, 0, 0, 1, 0, 0, 0, 0, 16'h0000);
    add(1, 4, 0, 0, 0, 0, 0, 1, 0, 0, 0, 0, 16'h0010);
    add(1, 0, 0, 4, 0, 0, 1, 0, 0, 0, 1, 0, 16'h0010);
    add(1, 0, 0, 4, 0, 0, 1, 0, 0, 0, 1, 0, 16'h0010);
    add(1, 0, 0, 4, 0, 0, 1, 0, 0, 0, 1, 0, 16'h0010);
    add(1, 0, 0, 4, 0, 0, 1, 0, 0, 0, 0, 0, 16'h0000);
    // SPWrite base R1 with self-read, then A2 (RegSrcD=1) reader of R1.
    add(1, 0, 1, 0, 0, 1, 0, 0, 1, 0, 0, 0, 16'h0000);
    add(1, 1, 0, 0, 1, 0, 1, 0, 0, 0, 1, 0, 16'h0002);
    add(1, 1, 0, 0, 1, 0, 1, 0, 0, 0, 1, 0, 16'h0002);
    add(1, 1, 0, 0, 1, 0, 1, 0, 0, 0, 1, 0, 16'h0002);
    add(1, 1, 0, 0, 1, 0, 1, 0, 0, 0, 0, 0, 16'h0000);
    // Dual writes: distinct regs R10/R11, then both to R12.
    add(1, 10, 11, 0, 0, 0, 0, 1, 1, 0, 0, 0, 16'h0000);
    add(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 16'h0C00);
    add(1, 12, 12, 0, 0, 0, 0, 1, 1, 0, 0, 0, 16'h0C00);
    add(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 16'h1C00);
    add(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 16'h1000);
    add(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 16'h1000);
    add(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 16'h0000);
    // Drain with pending R6; independent reader R0 held only by the drain.
    add(1, 6, 0, 0, 0, 0, 0, 1, 0, 0, 0, 0, 16'h0000);
    add(0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0, 0, 16'h0040);
    add(1, 0, 0, 0, 0, 1, 0, 0, 0, 1, 1, 0, 16'h0040);
    add(1, 0, 0, 0, 0, 1, 0, 0, 0, 1, 1, 0, 16'h0040);
    add(1, 0, 0, 0, 0, 1, 0, 0, 0, 1, 1, 0, 16'h0000);
    add(1, 0, 0, 0, 0, 1, 0, 0, 0, 1, 1, 1, 16'h0000);
    add(1, 0, 0, 0, 0, 1, 0, 0, 0, 0, 0, 0, 16'h0000);
    // DrainReq withdrawn while DRAINING.
    add(1, 6, 0, 0, 0, 0, 0, 1, 0, 0, 0, 0, 16'h0000);
    add(0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0, 0, 16'h0040);
    add(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0, 16'h0040);
    add(1, 0, 0, 0, 0, 1, 0, 0, 0, 0, 0, 0, 16'h0040);
    add(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 16'h0000);
    // Drain on an empty scoreboard: one DRAINING cycle, then DRAINED.
    add(0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0, 0, 16'h0000);
    add(0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 1, 0, 16'h0000);
    add(0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 1, 1, 16'h0000);
    add(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 16'h0000);
    add(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 16'h0000);

    // Reset state.
    tmp = '{default: '0};
    drive(tmp);
    reset = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    chk_outs(-1, 1'b0, 1'b0, 16'h0000);
`ifdef HAZARD_PERF_EN
    chk("stallcnt_rst", -1, StallCount, 32'd0);
    chk("issuecnt_rst", -1, IssueCount, 32'd0);
`endif
    @(negedge clk);
    reset = 1'b0;

    // Table.
    for (int i = 0; i < nvec; i++) begin
      if (i != 0) @(negedge clk);
      drive(vecs[i]);
      #1;
      chk_outs(i, vecs[i].e_stall, vecs[i].e_ack, vecs[i].e_busy);
    end
`ifdef HAZARD_PERF_EN
    chk("stallcnt", nvec, StallCount, 32'd9);
    chk("issuecnt", nvec, IssueCount, 32'd15);
`endif

    // Reset asserted mid-stall with cnt[3] = 2.
    @(negedge clk);
    tmp = '{default: '0};
    tmp.v = 1'b1; tmp.rd = 4'd3; tmp.rw = 1'b1;
    drive(tmp);
    @(negedge clk);
    tmp = '{default: '0};
    tmp.v = 1'b1; tmp.rb = 4'd3; tmp.a1 = 1'b1;
    drive(tmp);
    #1;
    chk_outs(100, 1'b1, 1'b0, 16'h0008);
    @(negedge clk);
    #1;
    chk_outs(101, 1'b1, 1'b0, 16'h0008);
    #1 reset = 1'b1;
    #1;
    chk_outs(102, 1'b0, 1'b0, 16'h0000);
`ifdef HAZARD_PERF_EN
    chk("stallcnt_midrst", 102, StallCount, 32'd0);
    chk("issuecnt_midrst", 102, IssueCount, 32'd0);
`endif
    @(negedge clk);
    reset = 1'b0;
    #1;
    chk_outs(103, 1'b0, 1'b0, 16'h0000);
    @(negedge clk);
    tmp = '{default: '0};
    drive(tmp);
    #1;
    chk_outs(104, 1'b0, 1'b0, 16'h0000);
`ifdef HAZARD_PERF_EN
    chk("issuecnt_after", 104, IssueCount, 32'd1);
    chk("stallcnt_after", 104, StallCount, 32'd0);
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
